// File: rtl/isp_controller.sv
// In-system programming controller: parses LOAD/RUN commands from a host byte stream,
// writes assembled words into instruction memory and releases the core with an entry address.
module isp_controller #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_byte,
  output logic                    rx_ready,
  output logic [ADDRESS_BITS-1:0] isp_address,
  output logic [DATA_WIDTH-1:0]   isp_data,
  output logic                    isp_write,
  output logic [ADDRESS_BITS-1:0] program_address,
  output logic                    start,
  output logic                    core_hold,
  output logic                    busy,
  output logic                    error
);

  typedef enum logic [2:0] {IDLE, ADDR, COUNT, DATA, WRITE, ENTRY, START} state_t;

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_RUN  = 8'h02;

  state_t                  state;
  logic [1:0]              byte_count;
  logic [23:0]             shift;
  logic [15:0]             remaining;
  logic [ADDRESS_BITS-1:0] word_ptr;
  logic                    accept;
  logic                    last_byte;
  logic [31:0]             shifted;

  // Little-endian fields: each new byte enters at the top, so the first byte ends up at [7:0].
  assign shifted   = {rx_byte, shift};
  assign rx_ready  = !reset && (state != WRITE) && (state != START);
  assign accept    = rx_valid && rx_ready;
  assign last_byte = (byte_count == 2'd3);
  assign busy      = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      byte_count      <= 2'd0;
      shift           <= '0;
      remaining       <= '0;
      word_ptr        <= '0;
      isp_address     <= '0;
      isp_data        <= '0;
      isp_write       <= 1'b0;
      program_address <= '0;
      start           <= 1'b0;
      core_hold       <= 1'b1;
      error           <= 1'b0;
    end else begin
      // NOTE: strobes default low each cycle and are raised only on the transition into
      // their one-cycle state, so they come straight from flops and can never stretch.
      isp_write <= 1'b0;
      start     <= 1'b0;

      if (accept && state != IDLE) begin
        shift      <= shifted[31:8];
        byte_count <= byte_count + 2'd1;
      end

      unique case (state)
        IDLE: begin
          if (accept) begin
            if (rx_byte == CMD_LOAD) begin
              state     <= ADDR;
              core_hold <= 1'b1;
            end else if (rx_byte == CMD_RUN) begin
              state <= ENTRY;
            end else begin
              error <= 1'b1;
            end
          end
        end

        ADDR: begin
          if (accept && last_byte) begin
            word_ptr <= shifted[ADDRESS_BITS+1:2];
            state    <= COUNT;
          end
        end

        COUNT: begin
          if (accept && byte_count == 2'd1) begin
            byte_count <= 2'd0;
            remaining  <= {rx_byte, shift[23:16]};
            state      <= ({rx_byte, shift[23:16]} == 16'd0) ? IDLE : DATA;
          end
        end

        DATA: begin
          if (accept && last_byte) begin
            isp_data    <= shifted;
            isp_address <= word_ptr;
            isp_write   <= 1'b1;
            state       <= WRITE;
          end
        end

        WRITE: begin
          word_ptr  <= word_ptr + ADDRESS_BITS'(1);
          remaining <= remaining - 16'd1;
          state     <= (remaining == 16'd1) ? IDLE : DATA;
        end

        ENTRY: begin
          if (accept && last_byte) begin
            program_address <= shifted[ADDRESS_BITS-1:0];
            start           <= 1'b1;
            core_hold       <= 1'b0;
            state           <= START;
          end
        end

        START: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_isp_controller.sv
// Self-checking bench for isp_controller: directed and randomized LOAD/RUN command streams
// compared against expectations computed from the command format.
module tb_isp_controller;

  localparam int AB = 20;

  logic          clock = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_byte;
  logic          rx_ready;
  logic [AB-1:0] isp_address;
  logic [31:0]   isp_data;
  logic          isp_write;
  logic [AB-1:0] program_address;
  logic          start;
  logic          core_hold;
  logic          busy;
  logic          error;

  int checks = 0;
  int passes = 0;
  int write_count = 0;
  logic prev_wr = 1'b0;
  logic prev_st = 1'b0;
  logic [31:0] load_words[$];

  isp_controller #(.DATA_WIDTH(32), .ADDRESS_BITS(AB)) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ready(rx_ready),
    .isp_address(isp_address), .isp_data(isp_data), .isp_write(isp_write),
    .program_address(program_address), .start(start), .core_hold(core_hold),
    .busy(busy), .error(error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  // Strobe hygiene: one cycle wide and mutually exclusive.
  always @(negedge clock) begin
    if (isp_write || start) check("wr_start_exclusive", {31'b0, isp_write & start}, 32'd0);
    if (isp_write) check("isp_write_width", {31'b0, prev_wr}, 32'd0);
    if (start) check("start_width", {31'b0, prev_st}, 32'd0);
    prev_wr <= isp_write;
    prev_st <= start;
  end

  always @(posedge clock) if (isp_write) write_count <= write_count + 1;

  // Called and returns at a falling edge; returns on the falling edge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    logic ok;
    bit   done;
    done = 0;
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clock);
    rx_valid = 1'b1;
    rx_byte  = b;
    for (int i = 0; i < 16 && !done; i++) begin
      ok = rx_ready;
      @(negedge clock);
      if (ok) done = 1;
    end
    rx_valid = 1'b0;
    check("byte_accepted", {31'b0, done}, 32'd1);
  endtask

  task automatic send32(input logic [31:0] v);
    logic [31:0] t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      send_byte(t[7:0]);
      t = t >> 8;
    end
  endtask

  task automatic load_cmd(input logic [31:0] base);
    int          w0;
    logic [15:0] n;
    logic [AB-1:0] exp_addr;
    w0 = write_count;
    n  = 16'(load_words.size());
    send_byte(8'h01);
    check("load_core_hold", {31'b0, core_hold}, 32'd1);
    check("load_busy", {31'b0, busy}, 32'd1);
    send32(base);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    if (n == 16'd0) check("n0_back_idle", {31'b0, busy}, 32'd0);
    for (int i = 0; i < int'(n); i++) begin
      send32(load_words[i]);
      exp_addr = AB'((base >> 2) + 32'(i));
      check("write_strobe", {31'b0, isp_write}, 32'd1);
      check("write_address", 32'(isp_address), 32'(exp_addr));
      check("write_data", isp_data, load_words[i]);
    end
    @(negedge clock);
    check("write_count", 32'(write_count - w0), 32'(n));
    check("load_hold_after", {31'b0, core_hold}, 32'd1);
    check("load_idle_after", {31'b0, busy}, 32'd0);
  endtask

  task automatic run_cmd(input logic [31:0] entry);
    send_byte(8'h02);
    send32(entry);
    check("run_start", {31'b0, start}, 32'd1);
    check("run_core_hold_low", {31'b0, core_hold}, 32'd0);
    check("run_program_address", 32'(program_address), 32'(entry[AB-1:0]));
    @(negedge clock);
    check("run_start_ends", {31'b0, start}, 32'd0);
    check("run_busy_after", {31'b0, busy}, 32'd0);
    check("run_address_held", 32'(program_address), 32'(entry[AB-1:0]));
    check("run_core_running", {31'b0, core_hold}, 32'd0);
  endtask

  task automatic random_words(input int n);
    load_words.delete();
    for (int i = 0; i < n; i++) load_words.push_back($urandom);
  endtask

  initial begin
    int w0;
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
    check("rst_isp_write", {31'b0, isp_write}, 32'd0);
    check("rst_isp_data", isp_data, 32'd0);
    check("rst_isp_address", 32'(isp_address), 32'd0);
    check("rst_program_address", 32'(program_address), 32'd0);
    check("rst_start", {31'b0, start}, 32'd0);
    check("rst_core_hold", {31'b0, core_hold}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_error", {31'b0, error}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_rx_ready", {31'b0, rx_ready}, 32'd1);

    // Two-word load from the example program, then run it.
    load_words = '{32'h0000_0013, 32'h0010_0093};
    load_cmd(32'h0000_0100);
    run_cmd(32'h0000_0100);

    // Unknown command byte sets a sticky error; loading still works (and re-holds the core).
    send_byte(8'h7F);
    check("error_set", {31'b0, error}, 32'd1);
    check("error_idle", {31'b0, busy}, 32'd0);
    random_words(3);
    load_cmd(32'h0000_2000);
    check("error_sticky", {31'b0, error}, 32'd1);

    // Zero-length load.
    load_words.delete();
    load_cmd(32'h0000_0040);

    // Pointer wrap at the top of the address space.
    random_words(2);
    load_cmd(32'h003F_FFFC);

    // Back-to-back RUNs reissue start; LOAD while running re-holds the core.
    run_cmd($urandom);
    run_cmd($urandom);
    random_words(1);
    load_cmd($urandom);

    // Reset in the middle of a word discards it.
    w0 = write_count;
    send_byte(8'h01);
    send32(32'h0000_0800);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("midrst_rx_ready", {31'b0, rx_ready}, 32'd0);
    check("midrst_core_hold", {31'b0, core_hold}, 32'd1);
    check("midrst_error_clear", {31'b0, error}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_no_write", 32'(write_count - w0), 32'd0);
    random_words(2);
    load_cmd(32'h0000_0800);

    // Randomized mix of commands.
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        random_words(int'($urandom_range(0, 3)));
        load_cmd($urandom);
      end else begin
        run_cmd($urandom);
      end
    end

    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/isp_controller.md
# isp_controller

In-system programming controller for the single-cycle core's instruction memory. It receives a byte stream from a host link (UART/SPI front end) and parses LOAD and RUN commands. LOAD commands are assembled into 32-bit words and written through the fetch unit's ISP write port (`isp_address`/`isp_data`/`isp_write`). RUN commands release the core and pulse `start` with the entry address, which the fetch unit loads into its PC.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction word width; fixed at 32 (4 bytes per word).
- ADDRESS_BITS, 20, width of `isp_address` and `program_address`.

Ports:
- clock  in  1  core clock.
- reset  in  1  synchronous, active-high.
- rx_valid  in  1  host byte valid.
- rx_byte  in  8  host byte.
- rx_ready  out  1  byte accepted on a clock edge when rx_valid & rx_ready.
- isp_address  out  ADDRESS_BITS  word address for the instruction-memory write.
- isp_data  out  DATA_WIDTH  word to write.
- isp_write  out  1  one-cycle write strobe.
- program_address  out  ADDRESS_BITS  entry byte address presented with `start`.
- start  out  1  one-cycle start pulse to the fetch unit.
- core_hold  out  1  holds the core in reset while high.
- busy  out  1  high in any state other than IDLE.
- error  out  1  sticky; set by an unknown command byte.

## Operation
- Command format. All multi-byte fields are little-endian.
  - LOAD = 0x01, followed by: 4-byte base byte address, 2-byte word count N, then 4·N data bytes.
  - RUN = 0x02, followed by: 4-byte entry byte address.
- States: IDLE, ADDR, COUNT, DATA, WRITE, ENTRY, START.
- IDLE:
  - 0x01 → ADDR; sets core_hold = 1.
  - 0x02 → ENTRY.
  - Any other byte: set error, remain in IDLE. The byte is consumed.
- ADDR: collects 4 bytes → COUNT. The word pointer is loaded with base[ADDRESS_BITS+1:2]; base[1:0] is ignored and upper bits are truncated.
- COUNT: collects 2 bytes.
  - N = 0 → IDLE with no writes.
  - Otherwise → DATA.
- DATA: shifts bytes into the word; the first byte lands at bits [7:0]. The 4th byte → WRITE.
- WRITE: lasts one cycle.
  - isp_write = 1; isp_address = word pointer; isp_data = assembled word.
  - The pointer increments modulo 2^ADDRESS_BITS and the remaining count decrements.
  - Remaining count 0 → IDLE; otherwise → DATA.
- ENTRY: collects 4 bytes; program_address is loaded with the low ADDRESS_BITS bits. → START.
- START: lasts one cycle.
  - start = 1 and core_hold = 0 in this cycle; program_address is held afterwards.
  - → IDLE.
- rx_ready = !reset && state ∉ {WRITE, START}. Bytes are never dropped; the host stalls instead.
- A RUN arriving while the core is running reissues `start` with the new entry address.
- A LOAD arriving while the core is running re-asserts core_hold as soon as the command byte is accepted.

## Timing
- Reset values:
  - rx_ready 0 (during reset); isp_write 0; isp_data 0; isp_address 0.
  - program_address 0; start 0; core_hold 1; busy 0; error 0; state IDLE.
- rx_ready = 1 from the first cycle after reset deasserts.
- Write latency: the 4th data byte is accepted at edge t. WRITE (isp_write = 1) is the cycle after t. The next byte can be accepted at edge t+2.
- Throughput: at most one byte per cycle, plus one bubble cycle per word.
- RUN latency: the 4th entry byte is accepted at edge t. start = 1 for exactly the cycle after t. core_hold is low from that same cycle.
- start and isp_write are never high in the same cycle and are never wider than one cycle.
- isp_address/isp_data are registered and stable for the whole isp_write cycle.
- Reset mid-operation:
  - The FSM returns to IDLE; a partial word or count is discarded with no write issued.
  - core_hold returns to 1; error clears.
- Address wrap: pointer 0xFFFFF + 1 → 0x00000 (ADDRESS_BITS = 20).

## Test plan
- LOAD base 0x00000100, N = 2, data bytes 13 00 00 00 93 00 10 00 → isp_write pulses with (addr 0x40, data 0x00000013), then (addr 0x41, data 0x00100093). core_hold stays 1.
- RUN 0x00000100 after the load → one-cycle start with program_address = 0x100; core_hold falls in the same cycle; busy = 0 the next cycle.
- Byte 0x7F in IDLE → error = 1 and stays high. A following LOAD still completes normally.
- LOAD with N = 0 → no isp_write; FSM back in IDLE after the 2nd count byte.
- LOAD base 0x003FFFFC, N = 2 → writes at word address 0xFFFFF, then 0x00000.
- Reset asserted after the 2nd data byte of a word → no isp_write, core_hold = 1. A fresh LOAD then writes correctly.
